// File: rtl/gate_chk_pkg.sv
// Shared types and constants for gate_truth_checker: FSM state encoding,
// common 2-input truth tables and a counter-width helper.
package gate_chk_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Bit i is the expected output for input vector i, vector = {A,B}.
   localparam logic [3:0] TT_NAND2 = 4'b0111;
   localparam logic [3:0] TT_AND2  = 4'b1000;
   localparam logic [3:0] TT_OR2   = 4'b1110;
   localparam logic [3:0] TT_NOR2  = 4'b0001;
   localparam logic [3:0] TT_XOR2  = 4'b0110;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gate_chk_settle_timer.sv
// Settle-time counter for gate_truth_checker: counts cycles while enabled and
// flags the last settle cycle of the current vector.
module gate_chk_settle_timer
   import gate_chk_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = cnt_width(SETTLE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] count;

   // Holding at LAST keeps the count in range; the FSM leaves SETTLE anyway.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && !expired) begin
         count <= count + ONE;
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/gate_truth_checker.sv
// Exhaustive stimulus/response checker for an N-input combinational gate.
// Optional first-failure capture ports: define GATE_TRUTH_CHECKER_FAIL_CAPTURE_EN.
module gate_truth_checker
   import gate_chk_pkg::*;
#(
   parameter int unsigned N_INPUTS = 2,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter logic [2**N_INPUTS-1:0] EXPECT_TT = 4'b0111
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                resp,
   output logic [N_INPUTS-1:0] stim,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [N_INPUTS:0]   err_count
`ifdef GATE_TRUTH_CHECKER_FAIL_CAPTURE_EN
   ,
   output logic                first_fail_valid,
   output logic [N_INPUTS-1:0] first_fail_vec
`endif
);

   localparam logic [N_INPUTS-1:0] STIM_LAST = '1;
   localparam logic [N_INPUTS-1:0] STIM_ONE  = N_INPUTS'(1);
   localparam logic [N_INPUTS:0]   ERR_ONE   = (N_INPUTS + 1)'(1);

   state_t state;
   state_t state_nxt;
   logic   accept;
   logic   mismatch;
   logic   expired;
   logic   timer_clr;

   gate_chk_settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (timer_clr),
      .en      (state == SETTLE),
      .expired (expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      timer_clr = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (start) begin
               accept    = 1'b1;
               timer_clr = 1'b1;
               state_nxt = SETTLE;
            end
         end
         SETTLE: begin
            busy = 1'b1;
            if (expired) begin
               state_nxt = SAMPLE;
            end
         end
         SAMPLE: begin
            busy      = 1'b1;
            timer_clr = 1'b1;
            state_nxt = (stim == STIM_LAST) ? DONE : SETTLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mismatch = (resp != EXPECT_TT[stim]);
   assign pass     = done && (err_count == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stim      <= '0;
         err_count <= '0;
      end else if (accept) begin
         stim      <= '0;
         err_count <= '0;
      end else if (state == SAMPLE) begin
         if (mismatch) begin
            err_count <= err_count + ERR_ONE;
         end
         if (stim != STIM_LAST) begin
            stim <= stim + STIM_ONE;
         end
      end
   end

`ifdef GATE_TRUTH_CHECKER_FAIL_CAPTURE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else if (accept) begin
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else if (state == SAMPLE && mismatch && !first_fail_valid) begin
         first_fail_valid <= 1'b1;
         first_fail_vec   <= stim;
      end
   end
`endif

endmodule

// File: tb/tb_gate_truth_checker.sv
// Randomized bench for gate_truth_checker: two instances (default NAND2 timing
// and a 3-cycle settle with glitched response) checked against a timeline model.
module tb_gate_truth_checker;
   import gate_chk_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_a = 1'b0;
   logic       start_b = 1'b0;
   logic [3:0] func_a = TT_NAND2;
   logic [3:0] func_b = TT_NAND2;
   logic       glitch_b = 1'b1;
   logic       resp_a, resp_b;
   logic [1:0] stim_a, stim_b;
   logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
   logic [2:0] err_a, err_b;
`ifdef GATE_TRUTH_CHECKER_FAIL_CAPTURE_EN
   logic       ffv_a, ffv_b;
   logic [1:0] ffvec_a, ffvec_b;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign resp_a = func_a[stim_a];
   assign resp_b = glitch_b ? ~func_b[stim_b] : func_b[stim_b];

   gate_truth_checker #(
      .N_INPUTS      (2),
      .SETTLE_CYCLES (1),
      .EXPECT_TT     (TT_NAND2)
   ) dut_a (
      .clk       (clk),
      .rst       (rst),
      .start     (start_a),
      .resp      (resp_a),
      .stim      (stim_a),
      .busy      (busy_a),
      .done      (done_a),
      .pass      (pass_a),
      .err_count (err_a)
`ifdef GATE_TRUTH_CHECKER_FAIL_CAPTURE_EN
      ,
      .first_fail_valid (ffv_a),
      .first_fail_vec   (ffvec_a)
`endif
   );

   gate_truth_checker #(
      .N_INPUTS      (2),
      .SETTLE_CYCLES (3),
      .EXPECT_TT     (TT_NAND2)
   ) dut_b (
      .clk       (clk),
      .rst       (rst),
      .start     (start_b),
      .resp      (resp_b),
      .stim      (stim_b),
      .busy      (busy_b),
      .done      (done_b),
      .pass      (pass_b),
      .err_count (err_b)
`ifdef GATE_TRUTH_CHECKER_FAIL_CAPTURE_EN
      ,
      .first_fail_valid (ffv_b),
      .first_fail_vec   (ffvec_b)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: a vector fails when the gate's actual function disagrees with the table.
   function automatic int mism_count(input logic [3:0] f, input logic [3:0] tt);
      int n = 0;
      for (int i = 0; i < 4; i++) if (f[i] != tt[i]) n++;
      return n;
   endfunction

   function automatic int first_mism(input logic [3:0] f, input logic [3:0] tt);
      for (int i = 0; i < 4; i++) if (f[i] != tt[i]) return i;
      return 0;
   endfunction

   task automatic check_result_a(input logic [3:0] f);
      int n = mism_count(f, TT_NAND2);
      check("a_done", {31'b0, done_a}, 1);
      check("a_busy_end", {31'b0, busy_a}, 0);
      check("a_err", {29'b0, err_a}, n);
      check("a_pass", {31'b0, pass_a}, (n == 0) ? 1 : 0);
      check("a_stim_hold", {30'b0, stim_a}, 3);
`ifdef GATE_TRUTH_CHECKER_FAIL_CAPTURE_EN
      check("a_ffv", {31'b0, ffv_a}, (n != 0) ? 1 : 0);
      check("a_ffvec", {30'b0, ffvec_a}, first_mism(f, TT_NAND2));
`endif
   endtask

   // Called at a negedge; cycle c is the c-th clock period after the start edge.
   task automatic sweep_a(input logic [3:0] f, input bit poke);
      func_a  = f;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (c == 0) begin
            check("a_err_clr", {29'b0, err_a}, 0);
`ifdef GATE_TRUTH_CHECKER_FAIL_CAPTURE_EN
            check("a_ffv_clr", {31'b0, ffv_a}, 0);
`endif
         end
         check("a_stim", {30'b0, stim_a}, c / 2);
         check("a_busy_done", {30'b0, busy_a, done_a}, 2'b10);
         if (poke && c == 3) start_a = 1'b1;
         @(negedge clk);
         start_a = 1'b0;
      end
      check_result_a(f);
   endtask

   task automatic sweep_b(input logic [3:0] f);
      int n = mism_count(f, TT_NAND2);
      func_b   = f;
      glitch_b = 1'b1;
      start_b  = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int c = 0; c < 16; c++) begin
         glitch_b = ((c % 4) != 3);
         check("b_stim", {30'b0, stim_b}, c / 4);
         check("b_busy_done", {30'b0, busy_b, done_b}, 2'b10);
         @(negedge clk);
      end
      glitch_b = 1'b1;
      check("b_done", {31'b0, done_b}, 1);
      check("b_err", {29'b0, err_b}, n);
      check("b_pass", {31'b0, pass_b}, (n == 0) ? 1 : 0);
`ifdef GATE_TRUTH_CHECKER_FAIL_CAPTURE_EN
      check("b_ffv", {31'b0, ffv_b}, (n != 0) ? 1 : 0);
      check("b_ffvec", {30'b0, ffvec_b}, first_mism(f, TT_NAND2));
`endif
   endtask

   task automatic check_idle_a(input string tag);
      check(tag, {24'b0, stim_a, busy_a, done_a, pass_a, err_a}, 0);
`ifdef GATE_TRUTH_CHECKER_FAIL_CAPTURE_EN
      check({tag, "_ff"}, {29'b0, ffv_a, ffvec_a}, 0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      check_idle_a("rst_a");
      check("rst_b", {24'b0, stim_b, busy_b, done_b, pass_b, err_b}, 0);
      rst = 1'b0;
      @(negedge clk);
      check_idle_a("idle_a");

      sweep_a(TT_NAND2, 1'b0);
      sweep_a(TT_AND2, 1'b1);
      sweep_a(TT_NOR2, 1'b0);
      for (int k = 0; k < 6; k++) begin
         sweep_a(4'($urandom), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // Async reset while vector 2 is driven, after two mismatches were counted.
      func_a  = TT_AND2;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (4) @(negedge clk);
      check("a_vec2", {30'b0, stim_a}, 2);
      check("a_err_pre_rst", {29'b0, err_a}, 2);
      #2 rst = 1'b1;
      #1 check_idle_a("async_rst_a");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_a("post_rst_a");
      sweep_a(TT_XOR2, 1'b0);

      sweep_b(TT_NAND2);
      for (int k = 0; k < 3; k++) sweep_b(4'($urandom));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
